// File: rtl/video_line_fetcher.sv
// video_line_fetcher
//
// Drives the video controller's AXI read port. Each scanline request fetches
// one graphic line and/or one text row from RAM into the controller's line
// buffers. A fetch is split into INCR bursts of at most MAX_BURST beats, none
// crossing a 4 KB boundary. Graphic data is always fetched before text data,
// and only one burst is outstanding at a time.
//
// Line-buffer write timing: the write is issued in the same cycle as the R
// beat. buf_we/buf_data come straight from axi_r_valid/axi_r_payload_data and
// buf_addr/buf_sel come from registered state, so there is no extra cycle of
// latency between a beat and its buffer write.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   line_req               one-cycle request pulse for the next scanline
//   fetch_gfx, fetch_text  which parts to fetch (sampled with line_req)
//   gfx_line, text_row     line/row indices (sampled with line_req)
//   graphic_addr/_stride   graphic frame base and bytes per line
//   text_addr/_stride      text frame base and bytes per row
//   graphic_words          words per graphic line (0..2048)
//   text_words             words per text row (0..256)
//   axi_ar_*               read address channel (INCR bursts)
//   axi_r_*                read data channel (always ready)
//   buf_we/sel/addr/data   line-buffer write port (sel: 0 graphic, 1 text)
//   busy                   a fetch is in progress
//   done                   one-cycle pulse when a request completes
//   overrun                one-cycle pulse when a request is dropped while busy
//   protocol_err           sticky error for R-channel violations
module video_line_fetcher #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_req,
    input  logic        fetch_gfx,
    input  logic        fetch_text,
    input  logic [9:0]  gfx_line,
    input  logic [5:0]  text_row,
    input  logic [31:0] graphic_addr,
    input  logic [31:0] text_addr,
    input  logic [15:0] graphic_stride,
    input  logic [15:0] text_stride,
    input  logic [11:0] graphic_words,
    input  logic [8:0]  text_words,
    output logic        axi_ar_valid,
    input  logic        axi_ar_ready,
    output logic [31:0] axi_ar_payload_addr,
    output logic [7:0]  axi_ar_payload_len,
    output logic [1:0]  axi_ar_payload_burst,
    input  logic        axi_r_valid,
    output logic        axi_r_ready,
    input  logic [31:0] axi_r_payload_data,
    input  logic        axi_r_payload_last,
    output logic        buf_we,
    output logic        buf_sel,
    output logic [10:0] buf_addr,
    output logic [31:0] buf_data,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic        protocol_err
);

    localparam logic [12:0] MaxBurstW = 13'(MAX_BURST);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StAddr,
        StData,
        StNext
    } state_e;

    state_e      state_q, state_d;
    logic        gfx_pend_q, gfx_pend_d;
    logic        text_pend_q, text_pend_d;
    logic        src_q, src_d;
    logic [9:0]  gfx_line_q, gfx_line_d;
    logic [5:0]  text_row_q, text_row_d;
    logic [31:0] addr_q, addr_d;
    logic [11:0] remaining_q, remaining_d;
    logic [10:0] word_idx_q, word_idx_d;
    logic [8:0]  beats_q, beats_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        perr_q, perr_d;

    logic        has_gfx, has_text;
    logic [12:0] to_4k;
    logic [12:0] beats_calc;
    logic [31:0] sum_addr;
    logic        last_exp;
    logic        unused_beats_hi;

    assign has_gfx  = fetch_gfx && (graphic_words != 12'd0);
    assign has_text = fetch_text && (text_words != 9'd0);

    // Words left before the next 4 KB boundary (1..1024).
    assign to_4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> 2;

    always_comb begin
        beats_calc = {1'b0, remaining_q};
        if (beats_calc > MaxBurstW) begin
            beats_calc = MaxBurstW;
        end
        if (beats_calc > to_4k) begin
            beats_calc = to_4k;
        end
    end

    // beats_calc never exceeds MAX_BURST (<= 256), so the top bits are always zero.
    assign unused_beats_hi = ^beats_calc[12:9];

    assign last_exp = (beat_cnt_q == (beats_q - 9'd1));

    always_comb begin
        state_d     = state_q;
        gfx_pend_d  = gfx_pend_q;
        text_pend_d = text_pend_q;
        src_d       = src_q;
        gfx_line_d  = gfx_line_q;
        text_row_d  = text_row_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_idx_d  = word_idx_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        perr_d      = perr_q;
        sum_addr    = 32'd0;

        if (line_req && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
        // R beats are only legal while a burst is being received.
        if (axi_r_valid && (state_q != StData)) begin
            perr_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (line_req) begin
                    gfx_pend_d  = has_gfx;
                    text_pend_d = has_text;
                    gfx_line_d  = gfx_line;
                    text_row_d  = text_row;
                    if (!has_gfx && !has_text) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                word_idx_d = 11'd0;
                if (gfx_pend_q && (graphic_words != 12'd0)) begin
                    src_d       = 1'b0;
                    gfx_pend_d  = 1'b0;
                    sum_addr    = graphic_addr
                                + ({22'd0, gfx_line_q} * {16'd0, graphic_stride});
                    remaining_d = graphic_words;
                    state_d     = StAddr;
                end else if (text_pend_q && (text_words != 9'd0)) begin
                    src_d       = 1'b1;
                    text_pend_d = 1'b0;
                    sum_addr    = text_addr
                                + ({26'd0, text_row_q} * {16'd0, text_stride});
                    remaining_d = {3'd0, text_words};
                    state_d     = StAddr;
                end else begin
                    // Word counts dropped to zero under us: nothing left to fetch.
                    gfx_pend_d  = 1'b0;
                    text_pend_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
                addr_d = {sum_addr[31:2], 2'b00};
            end
            StAddr: begin
                if (axi_ar_ready) begin
                    beats_d    = beats_calc[8:0];
                    beat_cnt_d = 9'd0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (axi_r_valid) begin
                    word_idx_d  = word_idx_q + 11'd1;
                    remaining_d = remaining_q - 12'd1;
                    beat_cnt_d  = beat_cnt_q + 9'd1;
                    if (axi_r_payload_last != last_exp) begin
                        perr_d = 1'b1;
                    end
                    // Progress follows our own beat count, not r_last.
                    if (last_exp) begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                addr_d = addr_q + {21'd0, beats_q, 2'b00};
                if (remaining_q != 12'd0) begin
                    state_d = StAddr;
                end else if (!src_q && text_pend_q && (text_words != 9'd0)) begin
                    state_d = StCalc;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            gfx_pend_q  <= 1'b0;
            text_pend_q <= 1'b0;
            src_q       <= 1'b0;
            gfx_line_q  <= 10'd0;
            text_row_q  <= 6'd0;
            addr_q      <= 32'd0;
            remaining_q <= 12'd0;
            word_idx_q  <= 11'd0;
            beats_q     <= 9'd0;
            beat_cnt_q  <= 9'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gfx_pend_q  <= gfx_pend_d;
            text_pend_q <= text_pend_d;
            src_q       <= src_d;
            gfx_line_q  <= gfx_line_d;
            text_row_q  <= text_row_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_idx_q  <= word_idx_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            perr_q      <= perr_d;
        end
    end

    assign axi_ar_valid         = (state_q == StAddr);
    assign axi_ar_payload_addr  = addr_q;
    assign axi_ar_payload_len   = beats_calc[7:0] - 8'd1;
    assign axi_ar_payload_burst = 2'd1;
    assign axi_r_ready          = 1'b1;

    // Gated by reset so an aborted burst cannot write during the reset cycle.
    assign buf_we   = (state_q == StData) && axi_r_valid && !reset;
    assign buf_sel  = src_q;
    assign buf_addr = word_idx_q;
    assign buf_data = axi_r_payload_data;

    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign protocol_err = perr_q;

endmodule

// File: doc/video_line_fetcher.md
Name: video_line_fetcher

Overview:
- Sequences the video controller's AXI read port: on each scanline request, fetches one graphic line and optionally one text row from RAM into the controller's line buffers.
- Splits each fetch into INCR bursts of at most MAX_BURST beats; no burst crosses a 4 KB boundary.
- Graphic fetch is always served before text fetch; one burst outstanding at a time.
- Runs on the system clock; line requests arrive already synchronised from the pixel-clock domain.

Parameters:
- MAX_BURST, 16, maximum beats per AR burst (power of two, 1..256).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- line_req  in  1  one-cycle pulse: fetch data for the next scanline
- fetch_gfx  in  1  sampled with line_req: fetch a graphic line
- fetch_text  in  1  sampled with line_req: fetch a text row
- gfx_line  in  10  graphic line index, sampled with line_req
- text_row  in  6  text row index, sampled with line_req
- graphic_addr  in  32  graphic frame base, byte address
- text_addr  in  32  text frame base, byte address
- graphic_stride  in  16  bytes per graphic line
- text_stride  in  16  bytes per text row
- graphic_words  in  12  words per graphic line, 0..2048
- text_words  in  9  words per text row, 0..256
- axi_ar_valid  out  1  read address valid
- axi_ar_ready  in  1  read address ready
- axi_ar_payload_addr  out  32  burst start byte address, bits [1:0] = 0
- axi_ar_payload_len  out  8  beats-1
- axi_ar_payload_burst  out  2  constant 2'd1 (INCR)
- axi_r_valid  in  1  read data valid
- axi_r_ready  out  1  constant 1
- axi_r_payload_data  in  32  read data
- axi_r_payload_last  in  1  last beat of burst
- buf_we  out  1  line-buffer write strobe
- buf_sel  out  1  0 = graphic_line buffer, 1 = text_line buffer
- buf_addr  out  11  word index within the line
- buf_data  out  32  write data
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse when the request completes
- overrun  out  1  one-cycle pulse: line_req arrived while busy and was dropped
- protocol_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset values: axi_ar_valid=0, buf_we=0, busy=0, done=0, overrun=0, protocol_err=0, FSM=IDLE. Reset mid-burst aborts immediately; no further buf_we.
- States: IDLE, CALC, ADDR, DATA, NEXT.
- IDLE, line_req=1:
  - Latch fetch_gfx, fetch_text, gfx_line, text_row.
  - If neither fetch is requested, or both word counts are 0: pulse done next cycle and stay in IDLE.
  - Otherwise set busy and go to CALC.
- CALC (1 cycle): select the current source (graphic if pending and words≠0, else text). Set addr = base + index*stride (32-bit, wrap), with bits [1:0] forced to 0. Set remaining = words and word index = 0.
- ADDR:
  - Hold axi_ar_valid=1 with stable payload until axi_ar_ready.
  - beats = min(remaining, MAX_BURST, (4096 - addr[11:0])>>2); len = beats-1.
  - Latency: line_req at cycle N gives axi_ar_valid at N+2.
- DATA: on each axi_r_valid beat:
  - buf_we=1, buf_data=r data, buf_addr=word index, buf_sel=current source.
  - Increment word index; decrement remaining.
  - Write happens in the same cycle as the beat (combinational from the registered index), or registered +1 cycle. Pick one and document it in the RTL header; the bench tolerates either.
  - On the expected last beat go to NEXT.
- r_last mismatch: r_last=1 before the expected count, or 0 on the expected count, sets protocol_err. The FSM still advances on the beat count.
- NEXT:
  - addr += beats*4.
  - If remaining>0: go to ADDR.
  - Else if text is pending and text_words≠0 and the current source was graphic: go to CALC with text.
  - Else: clear busy, pulse done, go to IDLE.
- line_req while busy: pulse overrun for 1 cycle and ignore the request; the current fetch continues.
- buf_addr is zero-extended for text (max 255).
- No r beats are expected outside DATA. A stray axi_r_valid outside DATA sets protocol_err and is not written.

Test Plan:
- Graphic only: graphic_words=640, base 0x1000_0000, stride 2560, gfx_line=2, ar_ready=1 → 40 bursts of len 15. First addr 0x1000_1400. 640 buf_we with buf_sel=0 and buf_addr 0..639. One done pulse.
- 4 KB split: base 0x0000_0FF0, words=16, MAX_BURST=16 → burst 1 at 0xFF0 with len 3; burst 2 at 0x1000 with len 11.
- Graphic+text: 1280 graphic words and 80 text words, text_row=5, text_stride=320 → all graphic bursts precede the text bursts. Text starts at text_addr+1600. Text uses buf_sel=1 and buf_addr 0..79.
- Back-pressure: ar_ready low for 7 cycles → ar_valid and payload are held stable; no writes are lost.
- Overrun and early last: line_req while busy → one overrun pulse and the fetch completes normally. r_last on beat 3 of 16 → protocol_err=1 and stays set until reset.
- Reset on beat 5 of a burst → next cycle ar_valid=0, buf_we=0, busy=0. A following request starts cleanly.
